// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Funct3 decode helpers classify each op's class and operand signedness.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with pipeline Stall and a one-cycle Done pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              stall_s;

  logic              a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic              div_by_zero_s, div_ovf_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN+1:0]   div_diff_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

  assign a_neg_s = a_is_signed(Funct3) & SrcA[XLEN-1];
  assign b_neg_s = b_is_signed(Funct3) & SrcB[XLEN-1];
  assign a_mag_s = a_neg_s ? (~SrcA + {{(XLEN-1){1'b0}}, 1'b1}) : SrcA;
  assign b_mag_s = b_neg_s ? (~SrcB + {{(XLEN-1){1'b0}}, 1'b1}) : SrcB;

  assign div_by_zero_s = is_div_op(Funct3) && (SrcB == {XLEN{1'b0}});
  assign div_ovf_s     = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                         (SrcA == MIN_NEG) && (SrcB == ALL_ONES);

  // Partial sums for one iteration of each algorithm; the remainder keeps a spare top bit.
  assign mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
  assign div_diff_s = {rem_q, prod_q[XLEN-1]} - {2'b00, b_q};

  assign prod_fix_s = (sign_a_q ^ sign_b_q) ? (~prod_q + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_q;
  assign quo_fix_s  = (sign_a_q ^ sign_b_q) ? (~prod_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                                            : prod_q[XLEN-1:0];
  assign rem_fix_s  = sign_a_q ? (~rem_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : rem_q[XLEN-1:0];

  // Next-state, datapath update and Stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    stall_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          stall_s  = 1'b1;
          f3_d     = Funct3;
          a_d      = a_mag_s;
          b_d      = b_mag_s;
          sign_a_d = a_neg_s;
          sign_b_d = b_neg_s;
          rem_d    = {(XLEN+1){1'b0}};
          prod_d   = {{XLEN{1'b0}}, (is_div_op(Funct3) ? a_mag_s : b_mag_s)};
          if (div_by_zero_s) begin
            state_d  = DONE;
            result_d = Funct3[1] ? SrcA : ALL_ONES;
          end else if (div_ovf_s) begin
            state_d  = DONE;
            result_d = Funct3[1] ? {XLEN{1'b0}} : MIN_NEG;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(XLEN);
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        stall_s = 1'b1;
        if (Flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (is_div_op(f3_q)) begin
            prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], ~div_diff_s[XLEN+1]};
            if (!div_diff_s[XLEN+1]) begin
              rem_d = div_diff_s[XLEN:0];
            end else begin
              rem_d = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
            end
          end else begin
            if (prod_q[0]) begin
              prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
            end else begin
              prod_d = {1'b0, prod_q[2*XLEN-1:1]};
            end
          end
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      FIX: begin
        stall_s = 1'b1;
        if (Flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          case (f3_q)
            F3_MUL:                       result_d = prod_fix_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_d = quo_fix_s;
            F3_REM, F3_REMU:              result_d = rem_fix_s;
            default:                      result_d = result_q;
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      f3_q     <= 3'b000;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      prod_q   <= {(2*XLEN){1'b0}};
      rem_q    <= {(XLEN+1){1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign Stall  = stall_s;
  assign Done   = done_q;
  assign Result = result_q;

endmodule
